// File: rtl/alu_pkg.sv
// Shared definitions for the ALU board datapath.
//  - ALU_DATA_W / ALU_OP_W : default operand and opcode widths, shared by the
//    operand loader, the ALU core and the display stages.
//  - step_t                : load-sequencer steps. The encoding is visible on the
//    step indicator LEDs, so the values are fixed.
package alu_pkg;

   localparam int ALU_DATA_W = 8;
   localparam int ALU_OP_W   = 4;

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      ISSUE  = 2'd2,
      WAIT   = 2'd3
   } step_t;

endpackage

// File: rtl/alu_operand_loader_btn_debounce.sv
// Button conditioner: synchroniser, debounce counter and press-pulse generator.
// Ports:
//  clk   in   system clock
//  rst_n in   asynchronous active-low reset
//  raw   in   raw button level, asynchronous, active-high
//  level out  debounced (accepted) button level
//  press out  one-cycle pulse on each accepted 0->1 transition
// The accepted level follows the synchronised level only after it has
// differed for DEBOUNCE_CYCLES consecutive cycles; any agreement in between
// restarts the count. Raw edge to press pulse is 2 + DEBOUNCE_CYCLES cycles.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_q1;
   logic             sync_q2;
   logic [CNT_W-1:0] cnt;

   // NOTE: non-blocking assignments in clocked processes, so every flop samples
   // the pre-edge value of the others regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
         cnt     <= '0;
         level   <= 1'b0;
         press   <= 1'b0;
      end else begin
         sync_q1 <= raw;
         sync_q2 <= sync_q1;
         press   <= 1'b0;
         if (sync_q2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            // Counter stops at CNT_LAST and is cleared by the flip, so it never wraps.
            level <= sync_q2;
            cnt   <= '0;
            press <= sync_q2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_operand_loader.sv
// ALU operand loader: input stage of the ALU board.
// Load button press 1 captures sw_data into A, press 2 into B, press 3 issues
// {A, B, sw_op} to the ALU over a valid/ready handshake. Clear button returns
// everything to zero and aborts a pending issue.
// Ports:
//  clk, rst_n     clock, asynchronous active-low reset
//  btn_load_raw   raw centre button (async, active-high)
//  btn_clear_raw  raw up button (async, active-high)
//  sw_data        operand switches, sampled on a capture
//  sw_op          opcode switches, sampled on issue
//  a_out, b_out   registered operands (kept after issue for display)
//  op_out         registered opcode, stable while op_valid
//  op_valid       issue request, op_ready accepts on a rising edge
//  led_out        {a_out, b_out} LED mirror
//  step_out       current sequencer step
module alu_operand_loader
   import alu_pkg::*;
#(
   parameter int DATA_W          = ALU_DATA_W,
   parameter int OP_W            = ALU_OP_W,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                btn_load_raw,
   input  logic                btn_clear_raw,
   input  logic [DATA_W-1:0]   sw_data,
   input  logic [OP_W-1:0]     sw_op,
   output logic [DATA_W-1:0]   a_out,
   output logic [DATA_W-1:0]   b_out,
   output logic [OP_W-1:0]     op_out,
   output logic                op_valid,
   input  logic                op_ready,
   output logic [2*DATA_W-1:0] led_out,
   output logic [1:0]          step_out
);

   step_t             state, state_nxt;
   logic [DATA_W-1:0] a_nxt, b_nxt;
   logic [OP_W-1:0]   op_nxt;
   logic              valid_nxt;

   logic load_press, clear_press;
   logic load_level, clear_level;
   logic [1:0] unused_levels;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_load_raw),
      .level (load_level),
      .press (load_press)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_clear_raw),
      .level (clear_level),
      .press (clear_press)
   );

   // Only the press pulses drive the sequencer; the levels are not needed here.
   assign unused_levels = {load_level, clear_level};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= LOAD_A;
         a_out    <= '0;
         b_out    <= '0;
         op_out   <= '0;
         op_valid <= 1'b0;
      end else begin
         state    <= state_nxt;
         a_out    <= a_nxt;
         b_out    <= b_nxt;
         op_out   <= op_nxt;
         op_valid <= valid_nxt;
      end
   end

   // NOTE: every signal gets its hold value first, so no path through the
   // case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      a_nxt     = a_out;
      b_nxt     = b_out;
      op_nxt    = op_out;
      valid_nxt = op_valid;

      if (clear_press) begin
         // Clear wins over a same-cycle load press or handshake completion.
         state_nxt = LOAD_A;
         a_nxt     = '0;
         b_nxt     = '0;
         op_nxt    = '0;
         valid_nxt = 1'b0;
      end else begin
         case (state)
            LOAD_A: if (load_press) begin
               a_nxt     = sw_data;
               state_nxt = LOAD_B;
            end
            LOAD_B: if (load_press) begin
               b_nxt     = sw_data;
               state_nxt = ISSUE;
            end
            ISSUE: if (load_press) begin
               op_nxt    = sw_op;
               valid_nxt = 1'b1;
               state_nxt = WAIT;
            end
            WAIT: if (op_valid && op_ready) begin
               // Load presses here are dropped; A/B stay for display.
               valid_nxt = 1'b0;
               state_nxt = LOAD_A;
            end
            default: state_nxt = LOAD_A;
         endcase
      end
   end

   assign led_out  = {a_out, b_out};
   assign step_out = state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader with DEBOUNCE_CYCLES=4.
// A behavioural model (sample history + run-length debounce + step sequencer)
// is advanced and compared on every falling edge; directed scenarios add
// hand-computed literal expectations, then a randomized phase follows.
module tb_alu_operand_loader;

   localparam int DEB = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_load_raw = 1'b0;
   logic       btn_clear_raw = 1'b0;
   logic [7:0] sw_data = '0;
   logic [3:0] sw_op = '0;
   logic       op_ready = 1'b0;
   logic [7:0] a_out, b_out;
   logic [3:0] op_out;
   logic       op_valid;
   logic [15:0] led_out;
   logic [1:0] step_out;

   int n_checks = 0;
   int n_pass   = 0;

   alu_operand_loader #(
      .DATA_W          (8),
      .OP_W            (4),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .btn_load_raw  (btn_load_raw),
      .btn_clear_raw (btn_clear_raw),
      .sw_data       (sw_data),
      .sw_op         (sw_op),
      .a_out         (a_out),
      .b_out         (b_out),
      .op_out        (op_out),
      .op_valid      (op_valid),
      .op_ready      (op_ready),
      .led_out       (led_out),
      .step_out      (step_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else
         n_pass++;
   endtask

   // ---------------- behavioural model ----------------
   bit [7:0] m_a, m_b;
   bit [3:0] m_op;
   bit       m_valid;
   int       m_step;
   bit       m_ld_lvl, m_cl_lvl, m_ld_press, m_cl_press;
   int       m_ld_run, m_cl_run;
   bit       ld_hist[$];
   bit       cl_hist[$];

   task automatic model_reset();
      m_a = '0; m_b = '0; m_op = '0; m_valid = 1'b0; m_step = 0;
      m_ld_lvl = 1'b0; m_cl_lvl = 1'b0; m_ld_press = 1'b0; m_cl_press = 1'b0;
      m_ld_run = 0; m_cl_run = 0;
      ld_hist = '{1'b0, 1'b0};
      cl_hist = '{1'b0, 1'b0};
   endtask

   // A sample becomes the accepted level after DEB consecutive disagreeing cycles.
   function automatic void deb_update(input bit sample, inout bit lvl, inout int run,
                                      output bit press);
      press = 1'b0;
      if (sample != lvl) run++;
      else run = 0;
      if (run == DEB) begin
         lvl   = sample;
         run   = 0;
         press = sample;
      end
   endfunction

   task automatic model_step();
      bit d;
      // Sequencer reacts to presses produced on the previous edge.
      if (m_cl_press) begin
         m_a = '0; m_b = '0; m_op = '0; m_valid = 1'b0; m_step = 0;
      end else begin
         case (m_step)
            0: if (m_ld_press) begin m_a = sw_data; m_step = 1; end
            1: if (m_ld_press) begin m_b = sw_data; m_step = 2; end
            2: if (m_ld_press) begin m_op = sw_op; m_valid = 1'b1; m_step = 3; end
            3: if (op_ready) begin m_valid = 1'b0; m_step = 0; end
            default: m_step = 0;
         endcase
      end
      // Raw sampled now is seen by the debounce logic two edges later.
      ld_hist.push_back(btn_load_raw);
      d = ld_hist.pop_front();
      deb_update(d, m_ld_lvl, m_ld_run, m_ld_press);
      cl_hist.push_back(btn_clear_raw);
      d = cl_hist.pop_front();
      deb_update(d, m_cl_lvl, m_cl_run, m_cl_press);
   endtask

   initial begin
      model_reset();
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            model_reset();
         end else begin
            model_step();
            check("model a_out",    a_out,    m_a);
            check("model b_out",    b_out,    m_b);
            check("model op_out",   op_out,   m_op);
            check("model op_valid", op_valid, m_valid);
            check("model led_out",  led_out,  {m_a, m_b});
            check("model step_out", step_out, m_step);
         end
      end
   end

   // ---------------- stimulus helpers (start/end 1 ns after a falling edge) ----------------
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic press_load(input logic [7:0] d, input logic [3:0] op);
      sw_data = d;
      sw_op   = op;
      btn_load_raw = 1'b1;
      cycles(10);
      btn_load_raw = 1'b0;
      cycles(10);
   endtask

   task automatic press_clear();
      btn_clear_raw = 1'b1;
      cycles(10);
      btn_clear_raw = 1'b0;
      cycles(10);
   endtask

   task automatic load_to_wait(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
      press_load(a, 4'h0);
      press_load(b, 4'h0);
      press_load(8'h00, op);
   endtask

   // Checks the A capture lands exactly 7 rising edges after the raw edge.
   task automatic timed_load(input logic [7:0] d, input logic [7:0] a_before);
      sw_data = d;
      btn_load_raw = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("a_out before 7th edge", a_out, a_before);
      @(posedge clk);
      #1;
      check("a_out at 7th edge", a_out, d);
      check("step_out after capture", step_out, 2'd1);
      @(negedge clk);
      #1;
      cycles(12);
      btn_load_raw = 1'b0;
      cycles(10);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, " a_out"},    a_out,    8'h00);
      check({tag, " b_out"},    b_out,    8'h00);
      check({tag, " op_out"},   op_out,   4'h0);
      check({tag, " op_valid"}, op_valid, 1'b0);
      check({tag, " step_out"}, step_out, 2'd0);
      check({tag, " led_out"},  led_out,  16'h0000);
   endtask

   // ---------------- scenarios ----------------
   initial begin
      int ld_hold, cl_hold;

      repeat (3) @(negedge clk);
      #1;
      check_cleared("reset");
      rst_n = 1'b1;
      cycles(2);

      // 1: exact capture latency
      timed_load(8'h3C, 8'h00);

      // 2: 3-cycle glitch is rejected
      btn_load_raw = 1'b1;
      cycles(3);
      btn_load_raw = 1'b0;
      cycles(12);
      check("glitch a_out", a_out, 8'h3C);
      check("glitch step_out", step_out, 2'd1);

      // 3: full sequence, ALU stalls, then accepts
      press_clear();
      load_to_wait(8'h3C, 8'hA5, 4'h6);
      cycles(10);
      check("stall op_valid", op_valid, 1'b1);
      check("stall op_out", op_out, 4'h6);
      check("stall a_out", a_out, 8'h3C);
      check("stall b_out", b_out, 8'hA5);
      check("stall step_out", step_out, 2'd3);
      op_ready = 1'b1;
      @(posedge clk);
      #1;
      check("accept op_valid", op_valid, 1'b0);
      check("accept step_out", step_out, 2'd0);
      check("accept a_out", a_out, 8'h3C);
      check("accept b_out", b_out, 8'hA5);
      @(negedge clk);
      #1;
      op_ready = 1'b0;
      cycles(2);

      // 4: load press in WAIT is ignored
      load_to_wait(8'h11, 8'h22, 4'h6);
      press_load(8'h44, 4'h9);
      check("wait-press op_out", op_out, 4'h6);
      check("wait-press step_out", step_out, 2'd3);
      check("wait-press a_out", a_out, 8'h11);
      op_ready = 1'b1;
      cycles(1);
      op_ready = 1'b0;
      check("wait-press handshake step_out", step_out, 2'd0);

      // 5: clear aborts a pending issue; then same with simultaneous load
      load_to_wait(8'h5A, 8'hC3, 4'hB);
      check("pre-clear op_valid", op_valid, 1'b1);
      press_clear();
      check_cleared("clear in WAIT");
      load_to_wait(8'h5A, 8'hC3, 4'hB);
      btn_load_raw  = 1'b1;
      btn_clear_raw = 1'b1;
      cycles(10);
      btn_load_raw  = 1'b0;
      btn_clear_raw = 1'b0;
      cycles(10);
      check_cleared("clear+load");

      // 6: async reset mid-debounce in LOAD_B
      press_load(8'h5A, 4'h0);
      check("pre-reset step_out", step_out, 2'd1);
      sw_data = 8'hC3;
      btn_load_raw = 1'b1;
      cycles(3);
      rst_n = 1'b0;
      #1;
      check_cleared("async reset");
      btn_load_raw = 1'b0;
      cycles(2);
      rst_n = 1'b1;
      cycles(2);
      timed_load(8'h77, 8'h00);

      // Randomized phase: independent button toggles, switches and ready.
      press_clear();
      ld_hold = 1;
      cl_hold = 40;
      for (int i = 0; i < 1500; i++) begin
         if (--ld_hold <= 0) begin
            btn_load_raw = ~btn_load_raw;
            ld_hold = $urandom_range(1, 12);
         end
         if (--cl_hold <= 0) begin
            btn_clear_raw = ~btn_clear_raw;
            cl_hold = btn_clear_raw ? $urandom_range(1, 8) : $urandom_range(20, 80);
         end
         sw_data  = 8'($urandom);
         sw_op    = 4'($urandom);
         op_ready = 1'($urandom_range(0, 1));
         cycles(1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
